lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl_pkg.sv | 24 ++
 rtl/lock_ctrl_timer.sv | 31 +++
 rtl/lock_ctrl.sv | 131 +++++++++++++
 tb/tb_lock_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_ctrl_pkg.sv
// Shared definitions for the keypad lock: key codes, FSM state encoding and
// the factory password.
package lock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_SETPW   = 2'd2,
    ST_LOCKOUT = 2'd3
  } lock_state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLOSE = 4'hC;
  localparam logic [3:0] KEY_SET   = 4'hD;

  // First digit lives in the most significant nibble.
  localparam logic [15:0] DEF_PASSWORD = 16'h1234;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_ctrl_timer.sv
// Lockout down-counter. A start pulse loads the count; busy stays high until
// the count drains to zero.
module lock_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(CYCLES + 1);
  // start arrives one cycle after the FSM enters lockout, and the FSM acts on
  // busy one edge later, so two cycles of the window are spent outside the count.
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: FSM, digit entry buffer, password compare and
// password change, with a timed lockout after repeated wrong entries.
module lock_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int                  PW_LEN      = 4,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  LOCK_CYCLES = 1000,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW  = DEF_PASSWORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        open,
  output logic        err_pulse,
  output logic        alarm,
  output logic [2:0]  digit_cnt,
  output lock_state_t state_dbg
);

  // key_valid is a single-cycle strobe with no backpressure: every cycle it is
  // high, key_code is consumed (or deliberately ignored) on that clk edge.

  localparam int         PW_W = 4 * PW_LEN;
  localparam int         EW   = $clog2(MAX_TRIES + 1);
  localparam logic [2:0] FULL = 3'(PW_LEN);

  lock_state_t      state;
  logic [PW_W-1:0]  entry_buf;
  logic [PW_W-1:0]  password;
  logic [EW-1:0]    err_cnt;
  logic             timer_start;
  logic             timer_busy;
  logic             entry_match;

  assign entry_match = (digit_cnt == FULL) && (entry_buf == password);
  assign state_dbg   = state;

  lock_timer #(
    .CYCLES (LOCK_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (timer_start),
    .busy  (timer_busy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      open        <= 1'b0;
      alarm       <= 1'b0;
      err_pulse   <= 1'b0;
      digit_cnt   <= 3'd0;
      entry_buf   <= '0;
      err_cnt     <= '0;
      timer_start <= 1'b0;
      password    <= DEFAULT_PW;
    end else begin
      err_pulse   <= 1'b0;
      timer_start <= 1'b0;
      if (state == ST_LOCKOUT) begin
        if (!timer_start && !timer_busy) begin
          state <= ST_IDLE;
          alarm <= 1'b0;
        end
      end else if (key_valid) begin
        if (is_digit(key_code)) begin
          if (digit_cnt != FULL) begin
            entry_buf <= PW_W'({entry_buf, key_code});
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            KEY_CLEAR: begin
              entry_buf <= '0;
              digit_cnt <= 3'd0;
            end
            KEY_ENTER: begin
              if (state == ST_IDLE) begin
                entry_buf <= '0;
                digit_cnt <= 3'd0;
                if (entry_match) begin
                  state   <= ST_OPEN;
                  open    <= 1'b1;
                  err_cnt <= '0;
                end else begin
                  err_pulse <= 1'b1;
                  if (err_cnt == EW'(MAX_TRIES - 1)) begin
                    state       <= ST_LOCKOUT;
                    alarm       <= 1'b1;
                    err_cnt     <= '0;
                    timer_start <= 1'b1;
                  end else begin
                    err_cnt <= err_cnt + EW'(1);
                  end
                end
              end else if (state == ST_SETPW) begin
                // A short entry returns to OPEN without touching the password.
                if (digit_cnt == FULL) begin
                  password <= entry_buf;
                end
                state     <= ST_OPEN;
                entry_buf <= '0;
                digit_cnt <= 3'd0;
              end
            end
            KEY_CLOSE: begin
              if (state == ST_OPEN || state == ST_SETPW) begin
                state     <= ST_IDLE;
                open      <= 1'b0;
                entry_buf <= '0;
                digit_cnt <= 3'd0;
              end
            end
            KEY_SET: begin
              if (state == ST_OPEN) begin
                state     <= ST_SETPW;
                entry_buf <= '0;
                digit_cnt <= 3'd0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed scenarios with literal expectations plus
// random key traffic checked every cycle against a digit-list model.
module tb_lock_ctrl;

  localparam int PW_LEN      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        key_valid = 1'b0;
  logic [3:0]  key_code  = 4'd0;
  logic        open;
  logic        err_pulse;
  logic        alarm;
  logic [2:0]  digit_cnt;
  lock_ctrl_pkg::lock_state_t state_dbg;

  int total = 0;
  int bad   = 0;

  lock_ctrl #(
    .PW_LEN      (PW_LEN),
    .MAX_TRIES   (MAX_TRIES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEFAULT_PW  (16'h1234)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .open      (open),
    .err_pulse (err_pulse),
    .alarm     (alarm),
    .digit_cnt (digit_cnt),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_entry[$];
  int   m_pw[PW_LEN];
  bit   m_open, m_setpw, m_err;
  int   m_tries, m_lock_left;
  logic [5:0] exp_q[$];

  task automatic model_reset();
    m_entry.delete();
    m_pw = '{1, 2, 3, 4};
    m_open = 0; m_setpw = 0; m_err = 0;
    m_tries = 0; m_lock_left = 0;
  endtask

  task automatic model_step();
    int k;
    bit ok;
    m_err = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (key_valid) begin
      k = int'(key_code);
      if (k <= 9) begin
        if (m_entry.size() < PW_LEN) m_entry.push_back(k);
      end else if (k == 10) begin
        m_entry.delete();
      end else if (k == 11) begin
        if (!m_open) begin
          ok = (m_entry.size() == PW_LEN);
          if (ok) for (int i = 0; i < PW_LEN; i++) if (m_entry[i] != m_pw[i]) ok = 0;
          if (ok) begin
            m_open = 1; m_tries = 0;
          end else begin
            m_err = 1; m_tries++;
            if (m_tries == MAX_TRIES) begin m_tries = 0; m_lock_left = LOCK_CYCLES; end
          end
          m_entry.delete();
        end else if (m_setpw) begin
          if (m_entry.size() == PW_LEN) for (int i = 0; i < PW_LEN; i++) m_pw[i] = m_entry[i];
          m_setpw = 0;
          m_entry.delete();
        end
      end else if (k == 12) begin
        if (m_open) begin m_open = 0; m_setpw = 0; m_entry.delete(); end
      end else if (k == 13) begin
        if (m_open && !m_setpw) begin m_setpw = 1; m_entry.delete(); end
      end
    end
  endtask

  initial begin
    logic [5:0] w;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
      w = {m_open, (m_lock_left > 0), m_err, 3'(m_entry.size())};
      exp_q.push_back(w);
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        exp_q.delete();
        check("open", int'(open), int'(e[5]));
        check("alarm", int'(alarm), int'(e[4]));
        check("err_pulse", int'(err_pulse), int'(e[3]));
        check("digit_cnt", int'(digit_cnt), int'(e[2:0]));
        check("open_alarm_excl", int'(open & alarm), 0);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_key(input logic [3:0] k);
    repeat ($urandom_range(0, 1)) @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
  endtask

  task automatic send_code(input logic [15:0] v);
    for (int i = 3; i >= 0; i--) send_key(v[i*4 +: 4]);
    send_key(4'hB);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_alarm_async", int'(alarm), 0);
    check("reset_open_async", int'(open), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int r;
    logic [15:0] code;
    repeat (2) @(negedge clk);
    check("rst_open", int'(open), 0);
    check("rst_alarm", int'(alarm), 0);
    check("rst_err", int'(err_pulse), 0);
    check("rst_digit_cnt", int'(digit_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // default password opens
    send_code(16'h1234);
    check("open_after_enter", int'(open), 1);
    check("cnt_after_enter", int'(digit_cnt), 0);
    send_key(4'hC);
    check("closed", int'(open), 0);

    // three wrong entries lock out for LOCK_CYCLES
    for (int t = 0; t < 3; t++) begin
      send_code(16'h1235);
      check("wrong_err_pulse", int'(err_pulse), 1);
    end
    check("lockout_alarm", int'(alarm), 1);
    n = 0;
    while (alarm && n < 2 * LOCK_CYCLES) begin
      if (n == 5) begin key_valid = 1'b1; key_code = 4'd7; end
      else key_valid = 1'b0;
      if (n == 7) check("lockout_digit_ignored", int'(digit_cnt), 0);
      n++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    check("alarm_len", n, LOCK_CYCLES);
    check("alarm_clear", int'(alarm), 0);
    send_key(4'd5);
    check("digit_after_lock", int'(digit_cnt), 1);
    send_key(4'hA);
    check("clear_cnt", int'(digit_cnt), 0);

    // short entry is wrong; fifth digit is ignored
    send_key(4'd1); send_key(4'd2); send_key(4'hB);
    check("short_err", int'(err_pulse), 1);
    for (int i = 0; i < 5; i++) send_key(4'(i + 1 == 5 ? 9 : i + 1));
    check("full_cnt", int'(digit_cnt), 4);
    send_key(4'hB);
    check("open_5th_ignored", int'(open), 1);

    // change password to 9876
    send_key(4'hD); send_code(16'h9876);
    check("open_in_setpw_done", int'(open), 1);
    send_key(4'hC);
    check("closed_after_set", int'(open), 0);
    send_code(16'h1234);
    check("old_pw_err", int'(err_pulse), 1);
    send_code(16'h9876);
    check("new_pw_open", int'(open), 1);
    send_key(4'hC);

    // random traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 19);
      if (r < 10) begin
        send_key(4'($urandom_range(0, 15)));
      end else if (r < 14) begin
        code = {4'(m_pw[0]), 4'(m_pw[1]), 4'(m_pw[2]), 4'(m_pw[3])};
        send_code(code);
      end else if (r < 15) begin
        send_code(16'($urandom_range(0, 16'h9999)) & 16'h7777);
      end else if (r < 17) begin
        send_key(4'hD);
      end else begin
        send_key(4'hC);
      end
    end
    while (m_lock_left > 0) @(negedge clk);

    // reset abandons SETPW
    do_reset();
    send_code(16'h1234);
    send_key(4'hD); send_key(4'd7); send_key(4'd7);
    do_reset();
    check("setpw_abort_cnt", int'(digit_cnt), 0);
    send_code(16'h1234);
    check("pw_after_setpw_reset", int'(open), 1);

    // reset mid-lockout drops alarm and restores password
    send_key(4'hD); send_code(16'h5555); send_key(4'hC);
    for (int t = 0; t < 3; t++) send_code(16'h1234);
    check("lock_with_new_pw", int'(alarm), 1);
    repeat (100) @(negedge clk);
    do_reset();
    check("alarm_after_reset", int'(alarm), 0);
    send_code(16'h1234);
    check("pw_reverted", int'(open), 1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
